// File: rtl/img_pkg.sv
// Shared image constants, pixel type and gray-to-RGB mapping.
// Build option: GRAY2RGB_HEATMAP_EN selects the heatmap palette.
package img_pkg;

   localparam int PIXEL_W        = 8;
   localparam int IMG_WIDTH_DEF  = 640;
   localparam int IMG_HEIGHT_DEF = 480;

   typedef struct packed {
      logic [PIXEL_W-1:0] r;
      logic [PIXEL_W-1:0] g;
      logic [PIXEL_W-1:0] b;
   } rgb_t;

   function automatic rgb_t gray_to_rgb(
      input logic [PIXEL_W-1:0] gray
   );
      rgb_t p;
`ifdef GRAY2RGB_HEATMAP_EN
      logic [PIXEL_W-1:0] d;
      // doubled offset from the half-scale point;
      // 255-d is simply the bitwise inverse of d
      d = {gray[PIXEL_W-2:0], 1'b0};
      if (!gray[PIXEL_W-1]) begin
         p.r = '0;
         p.g = d;
         p.b = ~d;
      end else begin
         p.r = d;
         p.g = ~d;
         p.b = '0;
      end
`else
      p.r = gray;
      p.g = gray;
      p.b = gray;
`endif
      return p;
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding mapped output pixels.
// Extra pointer bit separates full from empty.
module pixel_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   // pointer advance on accepted push/pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage write; contents need no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/gray2rgb_output.sv
// Gray-to-RGB output stage: buffering, frame position, done/err.
// Palette chosen by GRAY2RGB_HEATMAP_EN (see img_pkg).
module gray2rgb_output
   import img_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIXEL_W-1:0] gray_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic               done_i,
   output logic [PIXEL_W-1:0] r_o,
   output logic [PIXEL_W-1:0] g_o,
   output logic [PIXEL_W-1:0] b_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               sof_o,
   output logic               eol_o,
   output logic               done_o,
   output logic               err_o
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   logic          run;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   rgb_t          in_pix;
   rgb_t          head;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          col_last;
   logic          row_last;
   logic          at_origin;
   logic          frame_end;
   logic          pend;
   logic          pend_idle;
   logic          short_frame;

   assign in_pix  = gray_to_rgb(gray_i);
   assign ready_o = run && !full;
   assign valid_o = !empty;
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   // data outputs forced low whenever nothing is presented
   assign r_o = valid_o ? head.r : '0;
   assign g_o = valid_o ? head.g : '0;
   assign b_o = valid_o ? head.b : '0;

   assign col_last  = (col == CW'(IMG_WIDTH - 1));
   assign row_last  = (row == RW'(IMG_HEIGHT - 1));
   assign at_origin = (col == '0) && (row == '0);
   assign sof_o     = valid_o && at_origin;
   assign eol_o     = valid_o && col_last;

   // frame end wins; a pending done with an idle
   // FIFO either closes a short frame or is dropped
   assign frame_end   = pop && col_last && row_last;
   assign pend_idle   = pend && empty && !frame_end;
   assign short_frame = pend_idle && !at_origin;

   pixel_fifo #(
      .WIDTH ($bits(rgb_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_pix),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // frame position, done pulse, pending and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run    <= 1'b0;
         col    <= '0;
         row    <= '0;
         pend   <= 1'b0;
         done_o <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         run    <= 1'b1;
         done_o <= frame_end || short_frame;
         pend   <= done_i || (pend && !frame_end && !pend_idle);
         if (short_frame) begin
            err_o <= 1'b1;
            col   <= '0;
            row   <= '0;
         end else if (pop) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gray2rgb_output.sv
// Directed bench for gray2rgb_output (4x2 frame, 8-deep FIFO).
// Expected palette follows GRAY2RGB_HEATMAP_EN.
module tb_gray2rgb_output;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] gray_i = '0;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic       done_i = 1'b0;
   logic [7:0] r_o, g_o, b_o;
   logic       valid_o;
   logic       ready_i = 1'b0;
   logic       sof_o, eol_o, done_o, err_o;

   int checks = 0;
   int errors = 0;

   gray2rgb_output #(
      .IMG_WIDTH  (4),
      .IMG_HEIGHT (2),
      .FIFO_DEPTH (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .gray_i  (gray_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .done_i  (done_i),
      .r_o     (r_o),
      .g_o     (g_o),
      .b_o     (b_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .sof_o   (sof_o),
      .eol_o   (eol_o),
      .done_o  (done_o),
      .err_o   (err_o)
   );

   always #5 clk = ~clk;

   wire [23:0] rgb = {r_o, g_o, b_o};

   function automatic logic [23:0] exp_rgb(input int g);
`ifdef GRAY2RGB_HEATMAP_EN
      if (g < 128)
         return {8'd0, 8'(2 * g), 8'(255 - 2 * g)};
      else
         return {8'(2 * (g - 128)), 8'(255 - 2 * (g - 128)), 8'd0};
`else
      return {8'(g), 8'(g), 8'(g)};
`endif
   endfunction

   task automatic check(input string tag,
                        input logic [23:0] got,
                        input logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      valid_i = 1'b0;
      done_i = 1'b0;
      ready_i = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      tick();
      tick();
      check("rst_ready", 24'(ready_o), 24'd0);
      check("rst_valid", 24'(valid_o), 24'd0);
      check("rst_rgb", rgb, 24'd0);
      check("rst_done", 24'(done_o), 24'd0);
      check("rst_err", 24'(err_o), 24'd0);
      check("rst_sof", 24'(sof_o), 24'd0);
      rst = 1'b1;
      check("rel_ready0", 24'(ready_o), 24'd0);
      tick();
      check("rel_ready1", 24'(ready_o), 24'd1);

      // single pixel, 1-cycle latency
      ready_i = 1'b1;
      gray_i = 8'h40;
      valid_i = 1'b1;
      check("t1_empty", 24'(valid_o), 24'd0);
      tick();
      valid_i = 1'b0;
      check("t1_valid", 24'(valid_o), 24'd1);
      check("t1_rgb", rgb, exp_rgb(8'h40));
      check("t1_sof", 24'(sof_o), 24'd1);
      check("t1_eol", 24'(eol_o), 24'd0);
      tick();
      check("t1_drain", 24'(valid_o), 24'd0);

      // full 4x2 frame streamed
      do_reset();
      ready_i = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         valid_i = (i < 8);
         gray_i = 8'(i * 16 + 1);
         check($sformatf("t2_valid%0d", i), 24'(valid_o),
               24'(i >= 1 && i <= 8));
         if (i >= 1 && i <= 8) begin
            check($sformatf("t2_rgb%0d", i), rgb,
                  exp_rgb((i - 1) * 16 + 1));
            check($sformatf("t2_eol%0d", i), 24'(eol_o),
                  24'((i - 1) % 4 == 3));
            check($sformatf("t2_sof%0d", i), 24'(sof_o),
                  24'(i == 1));
         end
         check($sformatf("t2_done%0d", i), 24'(done_o),
               24'(i == 9));
         tick();
      end
      valid_i = 1'b0;
      check("t2_err", 24'(err_o), 24'd0);

      // backpressure fills FIFO
      do_reset();
      ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         valid_i = 1'b1;
         gray_i = 8'(8'h80 + 8'(i * 9));
         check($sformatf("t3_ready%0d", i), 24'(ready_o),
               24'(i < 8));
         tick();
      end
      valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t3_hold_v%0d", k), 24'(valid_o), 24'd1);
         check($sformatf("t3_hold_d%0d", k), rgb, exp_rgb(8'h80));
         check($sformatf("t3_hold_s%0d", k), 24'(sof_o), 24'd1);
         tick();
      end
      ready_i = 1'b1;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("t3_out_v%0d", j), 24'(valid_o), 24'd1);
         check($sformatf("t3_out_d%0d", j), rgb,
               exp_rgb(8'h80 + j * 9));
         check($sformatf("t3_out_e%0d", j), 24'(eol_o),
               24'(j % 4 == 3));
         tick();
      end
      check("t3_empty", 24'(valid_o), 24'd0);
      check("t3_done", 24'(done_o), 24'd1);
      tick();
      check("t3_done_off", 24'(done_o), 24'd0);

      // short frame via done_i
      do_reset();
      ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         valid_i = 1'b1;
         gray_i = 8'(8'h20 + i);
         tick();
      end
      valid_i = 1'b0;
      done_i = 1'b1;
      check("t4_last_v", 24'(valid_o), 24'd1);
      check("t4_last_d", rgb, exp_rgb(8'h24));
      tick();
      done_i = 1'b0;
      check("t4_drained", 24'(valid_o), 24'd0);
      check("t4_done_a", 24'(done_o), 24'd0);
      tick();
      check("t4_done_b", 24'(done_o), 24'd1);
      check("t4_err_b", 24'(err_o), 24'd1);
      tick();
      check("t4_done_c", 24'(done_o), 24'd0);
      check("t4_err_c", 24'(err_o), 24'd1);
      tick();
      check("t4_done_d", 24'(done_o), 24'd0);
      gray_i = 8'h11;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      check("t4_next_v", 24'(valid_o), 24'd1);
      check("t4_next_sof", 24'(sof_o), 24'd1);
      tick();

      // reset with buffered pixels
      ready_i = 1'b1;
      valid_i = 1'b1;
      gray_i = 8'h01;
      tick();
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         gray_i = 8'(8'h50 + i);
         tick();
      end
      valid_i = 1'b0;
      check("t5_pre_v", 24'(valid_o), 24'd1);
      check("t5_pre_sof", 24'(sof_o), 24'd0);
      #2;
      rst = 1'b0;
      #1;
      check("t5_rst_v", 24'(valid_o), 24'd0);
      check("t5_rst_rdy", 24'(ready_o), 24'd0);
      check("t5_rst_rgb", rgb, 24'd0);
      check("t5_rst_err", 24'(err_o), 24'd0);
      tick();
      rst = 1'b1;
      tick();
      gray_i = 8'hC8;
      valid_i = 1'b1;
      ready_i = 1'b1;
      tick();
      valid_i = 1'b0;
      check("t5_post_v", 24'(valid_o), 24'd1);
      check("t5_post_sof", 24'(sof_o), 24'd1);
      check("t5_post_d", rgb, exp_rgb(8'hC8));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray2rgb_output.md
GRAY2RGB_OUTPUT -- requirements
Module: gray2rgb_output

Interface
REQ-001 Parameter IMG_WIDTH, default 640, active pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 8, output buffer entries (power of two, >=2).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 gray_i  in  8  grayscale pixel from the processing pipeline.
REQ-007 valid_i  in  1  gray_i is valid.
REQ-008 ready_o  out  1  block can accept a pixel.
REQ-009 done_i  in  1  single-cycle upstream frame-done pulse.
REQ-010 r_o, g_o, b_o  out  8 each  output RGB888 pixel.
REQ-011 valid_o  out  1  output pixel is valid.
REQ-012 ready_i  in  1  downstream accepts the output pixel.
REQ-013 sof_o  out  1  qualifies the first pixel of a frame (col 0, row 0).
REQ-014 eol_o  out  1  qualifies the last pixel of a line.
REQ-015 done_o  out  1  single-cycle frame-complete pulse.
REQ-016 err_o  out  1  sticky short-frame flag.

Function
REQ-017 Input handshake: a pixel is accepted when valid_i && ready_o; ready_o = FIFO not full.
REQ-018 An accepted pixel is mapped to RGB and written to the FIFO in the same cycle.
REQ-019 valid_o = FIFO not empty; r_o/g_o/b_o show the FIFO head; an entry pops on valid_o && ready_i.
REQ-020 Latency from acceptance to valid_o is exactly 1 cycle when the FIFO is empty.
REQ-021 Push and pop in the same cycle leave the occupancy unchanged; when full, ready_o=0 and no push occurs; when empty, no pop occurs.
REQ-022 While valid_o=1 and ready_i=0, the output data and flags stay stable.
REQ-023 Column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) advance on each output handshake; the column wraps to 0 and increments the row.
REQ-024 sof_o = valid_o && col==0 && row==0; eol_o = valid_o && col==IMG_WIDTH-1.
REQ-025 A handshake on pixel (IMG_WIDTH-1, IMG_HEIGHT-1) produces done_o=1 for the next cycle and wraps both counters to 0.
REQ-026 done_i is latched into a pending flag; the flag clears when done_o fires.
REQ-027 If the flag is pending, the FIFO is empty, and the counters are not both 0: done_o=1, err_o set, counters cleared (short frame).
REQ-028 If the flag is pending and the counters are both 0 with the FIFO empty, the flag clears without a second done_o.
REQ-029 Frame-end done_o and short-frame done_o never fire in the same cycle; the frame-end case has priority.

Reset
REQ-030 While rst=0: FIFO emptied, counters 0, pending flag 0, and all outputs 0 (ready_o 0, rising to 1 the first cycle after release).
REQ-031 Reset mid-frame discards buffered pixels; the next accepted pixel is treated as sof.

Configuration
REQ-032 With macro GRAY2RGB_HEATMAP_EN undefined: R=G=B=gray_i.
REQ-033 With GRAY2RGB_HEATMAP_EN defined: for g<128, R=0, G=2g, B=255-2g; for g>=128, R=2(g-128), G=255-2(g-128), B=0; all results are 8-bit with no overflow.

Structure
REQ-034 Shared package img_pkg holds the PIXEL_W=8 constant, the RGB pixel typedef, the default IMG_WIDTH/IMG_HEIGHT, and the gray-to-RGB mapping function.
REQ-035 The FIFO is sub-module pixel_fifo (synchronous, parameterised width/depth, full/empty outputs); the counters and done logic stay in the top level.

Verification
REQ-036 Reset, then push gray 0x40 with ready_i=1 -> next cycle valid_o=1, RGB=40/40/40 (heatmap build: 00/80/7F), sof_o=1.
REQ-037 IMG_WIDTH=4, IMG_HEIGHT=2, stream 8 pixels with ready_i=1 -> eol_o on pixels 3 and 7, done_o pulse 1 cycle after pixel 7, err_o=0.
REQ-038 Hold ready_i=0 and push 9 pixels (FIFO_DEPTH=8) -> ready_o=0 after 8 accepts, data stable; release ready_i -> 8 pixels emerge in order.
REQ-039 IMG_WIDTH=4, IMG_HEIGHT=2, send 5 pixels then done_i -> done_o after the 5th pixel drains, err_o=1, next pixel flagged sof_o.
REQ-040 Assert rst=0 with 3 pixels buffered -> valid_o=0 and counters 0 immediately; after release, first pixel shows sof_o=1.
